// File: rtl/sequenciador_instrucoes_pkg.sv
// Shared types, constants and decode helper for the instruction sequencer.
package sequenciador_instrucoes_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 5;

  // Codops 0..5 are register-register, IMM_FIRST..OP_LAST_LEGAL carry imm4 in [7:4],
  // anything above OP_LAST_LEGAL is illegal.
  localparam logic [3:0] IMM_FIRST     = 4'd6;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } seq_state_e;

  // Instruction field layout: [15:12] codop, [11:8] dest, [7:4] srcA/imm4, [3:0] srcB.
  typedef struct packed {
    logic [3:0] codop;
    logic [3:0] dest;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } instr_t;

  // Everything the sequencer presents to the datapath for one instruction.
  typedef struct packed {
    logic [3:0]         codop;
    logic [ADDR_W-1:0]  end_a;
    logic [ADDR_W-1:0]  end_b;
    logic [ADDR_W-1:0]  end_c;
    logic               flag_imm;
    logic [INSTR_W-1:0] imm;
    logic               illegal;
  } issue_t;

  function automatic issue_t decode_instr(instr_t ins);
    issue_t d;
    d       = '0;
    d.codop = ins.codop;
    d.end_c = {1'b0, ins.dest};
    d.end_b = {1'b0, ins.src_b};
    if (ins.codop > OP_LAST_LEGAL) begin
      d.illegal = 1'b1;
    end else if (ins.codop >= IMM_FIRST) begin
      d.flag_imm = 1'b1;
      d.imm      = {12'b0, ins.src_a};
    end else begin
      d.end_a = {1'b0, ins.src_a};
    end
    return d;
  endfunction

endpackage

// File: rtl/sequenciador_instrucoes_fifo.sv
// Instruction queue: power-of-two depth, no bypass, asynchronous reset empties it.
module sequenciador_instrucoes_fifo
  import sequenciador_instrucoes_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = INSTR_W
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/sequenciador_instrucoes.sv
// Sequencer between the instruction source and the register-bank + ALU datapath.
// Each instruction goes ISSUE -> WAIT (RD_LAT+ALU_LAT cycles) -> WB; illegal codops
// skip straight back to IDLE after ISSUE.
module sequenciador_instrucoes
  import sequenciador_instrucoes_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   end_reg_a,
  output logic [ADDR_W-1:0]   end_reg_b,
  output logic [ADDR_W-1:0]   end_reg_c,
  output logic                banco_rw,
  output logic [INSTR_W-1:0]  dado_banco,
  output logic [INSTR_W-1:0]  imediato,
  output logic                flag_imediato,
  output logic [3:0]          codop,
  input  logic [INSTR_W-1:0]  resultado_alu,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [15:0]         retired_cnt,
  output logic [7:0]          illegal_cnt
);

  localparam int unsigned N    = RD_LAT + ALU_LAT;
  localparam int unsigned CntW = $clog2(N + 1);

  seq_state_e state_q, state_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;

  issue_t             issue_q, issue_d;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
  logic               banco_rw_q, banco_rw_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic [INSTR_W-1:0] dado_q, dado_d;
  logic [15:0]        retired_q, retired_d;
  logic [7:0]         ill_cnt_q, ill_cnt_d;

  sequenciador_instrucoes_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (INSTR_W)
  ) u_instr_fifo (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .push     (instr_valid & instr_ready),
    .pop      (fifo_pop),
    .wdata    (instr),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and queue pop; pops happen only from IDLE or WB.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        state_d = issue_q.illegal ? StIdle : StWait;
      end
      StWait: begin
        if (wait_cnt_q == CntW'(1)) begin
          state_d = StWb;
        end
      end
      StWb: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    issue_d    = issue_q;
    wait_cnt_d = wait_cnt_q;
    dado_d     = dado_q;
    retired_d  = retired_q;
    ill_cnt_d  = ill_cnt_q;
    banco_rw_d = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;

    // Decode on pop so the ISSUE-cycle outputs are already registered.
    if (fifo_pop) begin
      issue_d   = decode_instr(instr_t'(fifo_rdata));
      illegal_d = issue_d.illegal;
      if (issue_d.illegal && (ill_cnt_q != 8'hFF)) begin
        ill_cnt_d = ill_cnt_q + 8'd1;
      end
    end

    if (state_q == StIssue) begin
      wait_cnt_d = CntW'(N);
    end

    if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q - CntW'(1);
      // Last WAIT cycle: the ALU result is valid now.
      if (state_d == StWb) begin
        dado_d = resultado_alu;
      end
    end

    if (state_d == StWb) begin
      banco_rw_d = 1'b1;
      done_d     = 1'b1;
      retired_d  = retired_q + 16'd1;
    end
  end

  // Output and datapath-control registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      issue_q    <= '0;
      wait_cnt_q <= '0;
      banco_rw_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      dado_q     <= '0;
      retired_q  <= '0;
      ill_cnt_q  <= '0;
    end else begin
      issue_q    <= issue_d;
      wait_cnt_q <= wait_cnt_d;
      banco_rw_q <= banco_rw_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      dado_q     <= dado_d;
      retired_q  <= retired_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign instr_ready   = ~fifo_full;
  assign busy          = (state_q != StIdle) | ~fifo_empty;
  assign end_reg_a     = issue_q.end_a;
  assign end_reg_b     = issue_q.end_b;
  assign end_reg_c     = issue_q.end_c;
  assign codop         = issue_q.codop;
  assign flag_imediato = issue_q.flag_imm;
  assign imediato      = issue_q.imm;
  assign banco_rw      = banco_rw_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign dado_banco    = dado_q;
  assign retired_cnt   = retired_q;
  assign illegal_cnt   = ill_cnt_q;

endmodule
